pc_fetch_unit: RTL
==================

// Module: pc_fetch_unit
// PURPOSE
//   Program-counter and fetch stage of the single-cycle CPU; sits directly upstream of InsMemory.
//   Holds the PC, drives InsMemory's IAddr and returns the fetched word as Instr to decode.
//   Each cycle it selects the next PC from one of four sources: sequential, branch, jump or jump-register.
//   Detects the HALT opcode and freezes the PC. Keeps a count of retired instructions.
// PARAMETERS
//   RESET_PC     32'h0000_0000  PC value loaded on reset
//   HALT_OPCODE  6'b111111      Instr[31:26] value that stops the fetch
// PORTS
//   CLK        in   1   rising-edge clock
//   Reset      in   1   asynchronous reset, active-low
//   PCWre      in   1   PC write enable from control; 0 = hold the PC
//   PCSrc      in   2   next-PC select: 00 = PC+4, 01 = branch, 10 = jump, 11 = jump-register
//   Imm32      in   32  sign-extended branch offset, in words
//   JTarget    in   26  jump field, Instr[25:0]
//   RegAddr    in   32  jump-register target (rs value)
//   IDataOut   in   32  word read from InsMemory at IAddr
//   IAddr      out  32  current PC; wired to InsMemory.IAddr
//   PC4        out  32  IAddr+4, for link and branch arithmetic
//   Instr      out  32  fetched instruction; combinational copy of IDataOut
//   Halted     out  1   registered; 1 once HALT has been fetched
//   AddrErr    out  1   combinational; 1 when PCSrc=11 and RegAddr[1:0]!=0
//   InstCount  out  32  registered count of PC updates
// BEHAVIOUR
//   Reset (async, Reset=0):
//     - IAddr=RESET_PC, Halted=0, InstCount=0, state=RUN, immediately.
//     - Takes effect mid-cycle and from any state.
//   Arithmetic: all arithmetic is mod 2^32 and wraps silently, with no flag.
//     - PC4 = IAddr + 4.
//     - Branch target = PC4 + (Imm32 << 2).
//     - Jump target = {PC4[31:28], JTarget, 2'b00}.
//     - JR target = {RegAddr[31:2], 2'b00}. The low bits are always forced to 0.
//   NextPC is a combinational mux on PCSrc.
//   States:
//     - RUN
//     - HALT
//   RUN, rising CLK edge:
//     - PCWre=1 and Instr[31:26]!=HALT_OPCODE: IAddr<=NextPC, InstCount<=InstCount+1 (wraps).
//     - PCWre=1 and Instr[31:26]==HALT_OPCODE: IAddr holds, InstCount holds, state<=HALT, Halted<=1.
//       HALT takes priority over every PCSrc value.
//     - PCWre=0: IAddr, InstCount and state all hold. HALT is not detected while PCWre=0.
//   HALT:
//     - IAddr, InstCount and Halted hold. PCWre and PCSrc are ignored.
//     - The only exit is Reset.
//   Latency:
//     - Instr is valid in the same cycle as IAddr; InsMemory reads combinationally.
//     - The new PC is visible one CLK edge after selection.
//   AddrErr is informational only: it never blocks the update and never changes state.
//   No X may propagate to any output after reset, whatever the inputs.
// TESTING
//   1. Assert Reset low mid-cycle -> IAddr=0, Halted=0, InstCount=0 at once, without waiting for a CLK edge.
//   2. Release reset; PCWre=1, PCSrc=00 for 2 edges -> IAddr 0,4,8; InstCount=2; PC4=12.
//   3. At IAddr=8: PCSrc=01, Imm32=32'hFFFF_FFFE -> next IAddr=4. At IAddr=4: PCSrc=10, JTarget=26'h40 -> IAddr=32'h100.
//   4. PCSrc=11, RegAddr=32'h203 -> AddrErr=1 before the edge; IAddr=32'h200 after the edge.
//      Then PCWre=0 for 3 edges -> IAddr stays 32'h200.
//   5. IDataOut=32'hFC00_0000 with PCWre=1 -> Halted=1, IAddr and InstCount frozen.
//      Further edges with any PCSrc change nothing.
//   6. Drive IAddr to 32'hFFFF_FFFC via JR, then PCSrc=00 -> IAddr wraps to 0.
//      Reset while HALT -> back to RUN at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch stage: selects the next PC, presents the fetched word,
// freezes on the HALT opcode and counts PC updates.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        PCWre,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] Imm32,
    input  logic [25:0] JTarget,
    input  logic [31:0] RegAddr,
    input  logic [31:0] IDataOut,
    output logic [31:0] IAddr,
    output logic [31:0] PC4,
    output logic [31:0] Instr,
    output logic        Halted,
    output logic        AddrErr,
    output logic [31:0] InstCount
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetchState_t;

    fetchState_t state_r;
    fetchState_t stateNext_s;
    logic [31:0] pc_r;
    logic [31:0] pcNext_s;
    logic [31:0] selPc_s;
    logic [31:0] instCount_r;
    logic [31:0] instCountNext_s;
    logic        halted_r;
    logic        haltedNext_s;
    logic        isHalt_s;

    assign PC4       = pc_r + 32'd4;
    assign IAddr     = pc_r;
    assign Instr     = IDataOut;
    assign Halted    = halted_r;
    assign InstCount = instCount_r;
    assign AddrErr   = (PCSrc == 2'b11) && (RegAddr[1:0] != 2'b00);
    assign isHalt_s  = (IDataOut[31:26] == HALT_OPCODE);

    // Next-PC source mux; jump-register target is always forced word-aligned
    always_comb begin
        selPc_s = PC4;
        case (PCSrc)
            2'b00:   selPc_s = PC4;
            2'b01:   selPc_s = PC4 + {Imm32[29:0], 2'b00};
            2'b10:   selPc_s = {PC4[31:28], JTarget, 2'b00};
            2'b11:   selPc_s = {RegAddr[31:2], 2'b00};
            default: selPc_s = PC4;
        endcase
    end

    // Run/halt next-state logic; HALT outranks every PCSrc and is sticky until reset
    always_comb begin
        stateNext_s     = state_r;
        pcNext_s        = pc_r;
        instCountNext_s = instCount_r;
        haltedNext_s    = halted_r;
        case (state_r)
            RUN: begin
                if (PCWre) begin
                    if (isHalt_s) begin
                        stateNext_s  = HALT;
                        haltedNext_s = 1'b1;
                    end else begin
                        pcNext_s        = selPc_s;
                        instCountNext_s = instCount_r + 32'd1;
                    end
                end else begin
                    stateNext_s = RUN;
                end
            end
            HALT: begin
                stateNext_s  = HALT;
                haltedNext_s = 1'b1;
            end
            default: begin
                stateNext_s  = HALT;
                haltedNext_s = 1'b1;
            end
        endcase
    end

    // State, PC, retire counter and halt flag registers
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_r     <= RUN;
            pc_r        <= RESET_PC;
            instCount_r <= 32'd0;
            halted_r    <= 1'b0;
        end else begin
            state_r     <= stateNext_s;
            pc_r        <= pcNext_s;
            instCount_r <= instCountNext_s;
            halted_r    <= haltedNext_s;
        end
    end

endmodule
